fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_ADDR, default 32'h00000000, is the first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 redirect_valid  in  1  writeback-stage PC change (branch/jump taken).
REQ-005 redirect_pc  in  32  target PC from writeback stage (current_PC).
REQ-006 imem_req  out  1  instruction-memory request valid.
REQ-007 imem_addr  out  32  word-aligned request address.
REQ-008 imem_gnt  in  1  request accepted this cycle when imem_req=1.
REQ-009 imem_rvalid  in  1  response valid; one response per granted request, in order.
REQ-010 imem_rdata  in  32  instruction word.
REQ-011 if_valid  out  1  instruction available to decode.
REQ-012 if_ready  in  1  decode accepts instruction (low = stall).
REQ-013 if_instr  out  32  instruction word.
REQ-014 if_pc  out  32  address of if_instr.

Function
REQ-015 fetch_pc register SHALL hold the next address to request; imem_addr SHALL equal fetch_pc with bits [1:0] forced to 0.
REQ-016 FSM states: REQ (request may issue), WAIT (one request outstanding), KILL (outstanding response to be discarded).
REQ-017 At most one request outstanding; imem_req SHALL be 1 only in REQ and only when buffer occupancy < 2.
REQ-018 REQ with imem_gnt=1 -> WAIT; fetch_pc <= fetch_pc + 4 (32-bit wrap, 32'hFFFFFFFC + 4 = 0); granted address latched as pending_pc.
REQ-019 WAIT with imem_rvalid=1 -> REQ; {pending_pc, imem_rdata} pushed into buffer.
REQ-020 Buffer: 2-entry FIFO of {pc, instr}; if_valid = not empty; if_instr/if_pc = head entry; pop when if_valid and if_ready.
REQ-021 Simultaneous push and pop on a full or non-empty buffer SHALL keep order and occupancy correct; push into full buffer SHALL never occur (guaranteed by REQ-017).
REQ-022 redirect_valid SHALL take priority over all other events in the same cycle.
REQ-023 On redirect: fetch_pc <= {redirect_pc[31:2], 2'b00}; buffer flushed; if_valid = 0 next cycle; any same-cycle push or pop discarded.
REQ-024 On redirect in WAIT with imem_rvalid=0 -> KILL; in WAIT with imem_rvalid=1 -> REQ, response dropped; in REQ -> REQ (a same-cycle grant is treated as outstanding, -> KILL).
REQ-025 KILL: imem_req = 0; imem_rvalid=1 -> REQ, data dropped; further redirect in KILL updates fetch_pc only.
REQ-026 Steady-state throughput with if_ready=1 and single-cycle memory: one instruction per two cycles; latency request-grant to if_valid = 1 cycle after rvalid.
REQ-027 imem_rvalid outside WAIT/KILL SHALL be ignored.

Reset
REQ-028 While rst=1: fetch_pc = RESET_ADDR, state = REQ, buffer empty, if_valid = 0, imem_req = 0.
REQ-029 Reset mid-request SHALL abandon the outstanding response; first request after reset SHALL be to RESET_ADDR on the first clock edge with rst=0.

Structure
REQ-030 FSM state encoding and the instruction width constant SHALL live in the shared core package.
REQ-031 The 2-entry buffer SHALL be a sub-module fetch_buffer (push/pop/flush, full/empty, 64-bit entry).

Verification
REQ-032 Reset release, RESET_ADDR=32'h00000000, 1-cycle memory, if_ready=1 -> imem_addr sequence 0x0,0x4,0x8; if_pc follows same order with matching instr.
REQ-033 if_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req=0, no further grants; release -> entries popped in order, no loss.
REQ-034 Redirect to 32'h00000103 while WAIT -> next request 32'h00000100, stale response dropped, first if_pc = 32'h00000100.
REQ-035 Redirect and if_ready=1 pop same cycle with buffer full -> buffer empty next cycle, if_valid=0.
REQ-036 fetch_pc = 32'hFFFFFFFC granted -> next imem_addr 32'h00000000.
REQ-037 rst asserted in WAIT, late imem_rvalid after release -> response ignored; first if_pc = RESET_ADDR.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit:
//   - address / instruction widths
//   - fetch FSM state encoding
//   - fetch buffer entry layout ({pc, instr}, 64 bits)
//   - word_align(): clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  // REQ  : a request may issue
  // WAIT : one request outstanding, its response is wanted
  // KILL : one request outstanding, its response will be thrown away
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles the two handshakes of the fetch unit:
//   imem_*  : request/grant + in-order response channel to instruction memory
//   if_*    : valid/ready instruction channel towards decode
// Modports:
//   master : the fetch unit side (drives imem_req/addr and if_valid/instr/pc)
//   slave  : the memory + decode side
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid, if_instr, if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid, if_instr, if_pc,
    output if_ready
  );

endinterface

// File: rtl/fetch_unit_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// Two-entry FIFO of {pc, instr} entries between fetch and decode.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_push     : write i_data at the tail (ignored when full and not popping)
//   i_data     : entry to write
//   i_pop      : drop the head entry (ignored when empty)
//   i_flush    : empty the FIFO; overrides a same-cycle push and pop
//   o_head     : head entry (valid when !o_empty)
//   o_full     : two entries held
//   o_empty    : no entry held
// ---------------------------------------------------------------------------
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  fetch_entry_t r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push_ok) r_wptr <= ~r_wptr;
      if (w_pop_ok)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch: issues one word-aligned request at a time to instruction
// memory, queues responses in a 2-entry buffer and presents them to decode.
// A writeback redirect restarts fetching at a new PC, flushes the buffer and
// discards any response still in flight.
// Ports:
//   clk               : clock
//   rst               : asynchronous active-high reset
//   i_redirect_valid  : PC change from writeback (highest priority)
//   i_redirect_pc     : redirect target (low two bits ignored)
//   bus (master)      : imem_req/addr/gnt/rvalid/rdata, if_valid/ready/instr/pc
// Parameter:
//   RESET_ADDR        : first fetch address after reset
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  fetch_unit_if.master      bus
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_next;
  logic [ADDR_W-1:0] r_pending_pc;

  logic         w_imem_req;
  logic         w_grant;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  fetch_entry_t w_head;
  fetch_entry_t w_push_data;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_REQ;
      r_fetch_pc   <= RESET_ADDR;
      r_pending_pc <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      if (w_grant) r_pending_pc <= bus.imem_addr;
    end
  end

  // ---------------- next state / outputs ----------------
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    // rst gates the request so nothing is offered while reset is held.
    w_imem_req      = (r_state == ST_REQ) && !w_full && !rst;

    unique case (r_state)
      ST_REQ: begin
        // A grant in a redirect cycle fetched the old stream: kill its response.
        if (w_imem_req && bus.imem_gnt)
          w_state_next = i_redirect_valid ? ST_KILL : ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.imem_rvalid)         w_state_next = ST_REQ;
        else if (i_redirect_valid)   w_state_next = ST_KILL;
      end
      ST_KILL: begin
        if (bus.imem_rvalid) w_state_next = ST_REQ;
      end
      default: w_state_next = ST_REQ;
    endcase

    if (i_redirect_valid)
      w_fetch_pc_next = word_align(i_redirect_pc);
    else if (w_imem_req && bus.imem_gnt)
      w_fetch_pc_next = r_fetch_pc + 32'd4;
  end

  assign w_grant = w_imem_req && bus.imem_gnt;

  // Responses are only kept in WAIT; rvalid in REQ is stray and in KILL is stale.
  assign w_push      = (r_state == ST_WAIT) && bus.imem_rvalid && !i_redirect_valid;
  assign w_pop       = !w_empty && bus.if_ready && !i_redirect_valid;
  assign w_push_data = '{pc: r_pending_pc, instr: bus.imem_rdata};

  fetch_buffer u_buffer (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.imem_req  = w_imem_req;
  assign bus.imem_addr = word_align(r_fetch_pc);
  assign bus.if_valid  = !w_empty;
  assign bus.if_instr  = w_head.instr;
  assign bus.if_pc     = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Drives the fetch unit with a memory that answers in order after a random
// latency and a decode stage with random back-pressure. The reference keeps
// only the instruction-stream view: next expected request PC, next expected
// delivered PC, number of buffered instructions, and whether the single
// outstanding memory access will be used or discarded.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  fetch_unit_if bus();

  fetch_unit #(.RESET_ADDR(RST_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // sampled DUT outputs (taken at the falling edge)
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  // reference state
  logic [31:0] m_req_pc, m_pop_pc, m_addr;
  int          m_occ, m_wait;
  bit          m_busy, m_live;

  // what happened at the rising edge just simulated
  bit          ev_grant, ev_pop, ev_push;
  logic [31:0] ev_grant_addr, ev_pop_pc, ev_pop_instr, ev_exp_pop_pc;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic sample();
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.if_valid;
    s_pc    = bus.if_pc;
    s_instr = bus.if_instr;
  endtask

  task automatic model_reset();
    m_req_pc = RST_PC; m_pop_pc = RST_PC; m_occ = 0;
    m_busy = 0; m_live = 0; m_wait = 0; m_addr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.if_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 sample();
  endtask

  // One clock of stimulus: memory answers the outstanding access when its
  // latency expires, grants with probability gnt_pct, optionally emits a
  // stray rvalid while idle. Updates the reference, then samples outputs.
  task automatic drive_cycle(input bit ready, input bit redir, input logic [31:0] rpc,
                             input int gnt_pct, input int lat_min, input int lat_max,
                             input int junk_pct);
    bit rv, gnt;
    rv  = m_busy && (m_wait == 0);
    if (!m_busy && ($urandom_range(99) < junk_pct)) rv = 1;
    gnt = ($urandom_range(99) < gnt_pct);
    bus.imem_rvalid = rv;
    bus.imem_rdata  = (rv && m_busy) ? mem_fn(m_addr) : $urandom;
    bus.imem_gnt    = gnt;
    bus.if_ready    = ready;
    redirect_valid  = redir;
    redirect_pc     = rpc;

    ev_grant      = s_req && gnt;
    ev_grant_addr = s_addr;
    ev_pop        = s_valid && ready && !redir;
    ev_pop_pc     = s_pc;
    ev_pop_instr  = s_instr;
    ev_exp_pop_pc = m_pop_pc;
    ev_push       = rv && m_busy && m_live && !redir;

    if (rv && m_busy) m_busy = 0;
    else if (m_busy)  m_wait--;
    if (ev_grant) begin
      m_busy = 1; m_live = 1; m_addr = s_addr;
      m_wait = int'($urandom_range(lat_max, lat_min));
    end
    if (redir) m_live = 0;

    if (redir) m_occ = 0;
    else       m_occ = m_occ + int'(ev_push) - int'(ev_pop);
    if (redir)         m_pop_pc = {rpc[31:2], 2'b00};
    else if (ev_pop)   m_pop_pc = m_pop_pc + 32'd4;
    if (redir)         m_req_pc = {rpc[31:2], 2'b00};
    else if (ev_grant) m_req_pc = m_req_pc + 32'd4;

    @(negedge clk);
    sample();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.if_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got=%b exp=0", bus.if_valid); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req got=%b exp=0", bus.imem_req); end
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b1; bus.if_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_held_if_valid got=%b exp=0", bus.if_valid); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_held_imem_req got=%b exp=0", bus.imem_req); end
    rst = 1'b0;
    model_reset();
    #1 sample();
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL release_req got=%b exp=1", s_req); end
    checks++; if (s_addr !== RST_PC) begin errors++; $display("FAIL release_addr got=%h exp=%h", s_addr, RST_PC); end
    $display("test_reset done");
  endtask

  task automatic test_sequence();
    logic [31:0] grants[$];
    logic [31:0] pops[$];
    logic [31:0] instrs[$];
    logic [31:0] g, p, ins;
    int npop = 0;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      drive_cycle(1, 0, 32'h0, 100, 0, 0, 0);
      if (ev_grant) grants.push_back(ev_grant_addr);
      if (ev_pop) begin
        pops.push_back(ev_pop_pc); instrs.push_back(ev_pop_instr);
        $display("seq pop pc=%h instr=%h", ev_pop_pc, ev_pop_instr);
      end
      if (c == 0) begin checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL seq_latency_early got=%b exp=0", s_valid); end end
      if (c == 1) begin checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL seq_latency_valid got=%b exp=1", s_valid); end end
      if (c >= 6 && ev_pop) npop++;
    end
    for (int i = 0; i < 3; i++) begin
      g = (grants.size() > i) ? grants[i] : 32'hx;
      p = (pops.size() > i) ? pops[i] : 32'hx;
      ins = (instrs.size() > i) ? instrs[i] : 32'hx;
      checks++; if (g !== RST_PC + 32'(4*i)) begin errors++; $display("FAIL seq_addr%0d got=%h exp=%h", i, g, RST_PC + 32'(4*i)); end
      checks++; if (p !== RST_PC + 32'(4*i)) begin errors++; $display("FAIL seq_if_pc%0d got=%h exp=%h", i, p, RST_PC + 32'(4*i)); end
      checks++; if (ins !== mem_fn(RST_PC + 32'(4*i))) begin errors++; $display("FAIL seq_instr%0d got=%h exp=%h", i, ins, mem_fn(RST_PC + 32'(4*i))); end
    end
    checks++; if (npop != 10) begin errors++; $display("FAIL seq_throughput got=%0d exp=10", npop); end
  endtask

  task automatic test_stall();
    int ngr = 0;
    logic [31:0] pops[$];
    logic [31:0] p;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive_cycle(0, 0, 32'h0, 100, 0, 0, 0);
      if (ev_grant) ngr++;
    end
    checks++; if (ngr != 2) begin errors++; $display("FAIL stall_grants got=%0d exp=2", ngr); end
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got=%b exp=1", s_valid); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL stall_req got=%b exp=0", s_req); end
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1, 0, 32'h0, 100, 0, 0, 0);
      if (ev_pop) begin
        pops.push_back(ev_pop_pc);
        $display("stall pop pc=%h instr=%h", ev_pop_pc, ev_pop_instr);
        checks++; if (ev_pop_instr !== mem_fn(ev_pop_pc)) begin errors++; $display("FAIL stall_instr got=%h exp=%h", ev_pop_instr, mem_fn(ev_pop_pc)); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      p = (pops.size() > i) ? pops[i] : 32'hx;
      checks++; if (p !== RST_PC + 32'(4*i)) begin errors++; $display("FAIL stall_order%0d got=%h exp=%h", i, p, RST_PC + 32'(4*i)); end
    end
  endtask

  task automatic test_redirect_wait();
    logic [31:0] first_grant, first_pop, first_instr;
    bit got_grant = 0, got_pop = 0;
    first_grant = 32'hx; first_pop = 32'hx; first_instr = 32'hx;
    do_reset();
    drive_cycle(1, 0, 32'h0, 100, 2, 2, 0);
    drive_cycle(1, 1, 32'h00000103, 0, 0, 0, 0);
    for (int c = 0; c < 20 && !got_pop; c++) begin
      drive_cycle(1, 0, 32'h0, 100, 0, 0, 0);
      if (ev_grant && !got_grant) begin got_grant = 1; first_grant = ev_grant_addr; end
      if (ev_pop) begin
        got_pop = 1; first_pop = ev_pop_pc; first_instr = ev_pop_instr;
        $display("redir pop pc=%h instr=%h", ev_pop_pc, ev_pop_instr);
      end
    end
    checks++; if (first_grant !== 32'h00000100) begin errors++; $display("FAIL redir_req_addr got=%h exp=00000100", first_grant); end
    checks++; if (first_pop !== 32'h00000100) begin errors++; $display("FAIL redir_first_if_pc got=%h exp=00000100", first_pop); end
    checks++; if (first_instr !== mem_fn(32'h100)) begin errors++; $display("FAIL redir_first_instr got=%h exp=%h", first_instr, mem_fn(32'h100)); end
  endtask

  task automatic test_redirect_full_pop();
    logic [31:0] tgt, first_pop;
    bit got_pop = 0;
    first_pop = 32'hx;
    do_reset();
    repeat (10) drive_cycle(0, 0, 32'h0, 100, 0, 0, 0);
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got=%b exp=1", s_valid); end
    tgt = $urandom;
    drive_cycle(1, 1, tgt, 0, 0, 0, 0);
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", s_valid); end
    for (int c = 0; c < 10 && !got_pop; c++) begin
      drive_cycle(1, 0, 32'h0, 100, 0, 0, 0);
      if (ev_pop) begin got_pop = 1; first_pop = ev_pop_pc; $display("flush pop pc=%h instr=%h", ev_pop_pc, ev_pop_instr); end
    end
    checks++; if (first_pop !== {tgt[31:2], 2'b00}) begin errors++; $display("FAIL flush_first_pc got=%h exp=%h", first_pop, {tgt[31:2], 2'b00}); end
  endtask

  task automatic test_wrap();
    logic [31:0] grants[$];
    logic [31:0] pops[$];
    logic [31:0] g, p;
    logic [31:0] exp_seq[2];
    exp_seq[0] = 32'hFFFFFFFC; exp_seq[1] = 32'h00000000;
    do_reset();
    drive_cycle(1, 1, 32'hFFFFFFFC, 0, 0, 0, 0);
    for (int c = 0; c < 12; c++) begin
      drive_cycle(1, 0, 32'h0, 100, 0, 0, 0);
      if (ev_grant) grants.push_back(ev_grant_addr);
      if (ev_pop) begin pops.push_back(ev_pop_pc); $display("wrap pop pc=%h instr=%h", ev_pop_pc, ev_pop_instr); end
    end
    for (int i = 0; i < 2; i++) begin
      g = (grants.size() > i) ? grants[i] : 32'hx;
      p = (pops.size() > i) ? pops[i] : 32'hx;
      checks++; if (g !== exp_seq[i]) begin errors++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, g, exp_seq[i]); end
      checks++; if (p !== exp_seq[i]) begin errors++; $display("FAIL wrap_if_pc%0d got=%h exp=%h", i, p, exp_seq[i]); end
    end
  endtask

  task automatic test_reset_wait();
    logic [31:0] first_pop, first_instr;
    bit got_pop = 0;
    first_pop = 32'hx; first_instr = 32'hx;
    do_reset();
    drive_cycle(1, 0, 32'h0, 100, 3, 3, 0);
    drive_cycle(1, 0, 32'h0, 100, 3, 3, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 sample();
    checks++; if (s_req !== 1'b1 || s_addr !== RST_PC) begin errors++; $display("FAIL rstwait_req got=%b/%h exp=1/%h", s_req, s_addr, RST_PC); end
    // the late response from before reset shows up while no grant is given
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
    bus.if_ready = 1'b1; redirect_valid = 1'b0;
    @(negedge clk);
    sample();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rstwait_late_ignored got=%b exp=0", s_valid); end
    for (int c = 0; c < 10 && !got_pop; c++) begin
      drive_cycle(1, 0, 32'h0, 100, 0, 0, 0);
      if (ev_pop) begin got_pop = 1; first_pop = ev_pop_pc; first_instr = ev_pop_instr; $display("rstwait pop pc=%h instr=%h", ev_pop_pc, ev_pop_instr); end
    end
    checks++; if (first_pop !== RST_PC) begin errors++; $display("FAIL rstwait_first_pc got=%h exp=%h", first_pop, RST_PC); end
    checks++; if (first_instr !== mem_fn(RST_PC)) begin errors++; $display("FAIL rstwait_first_instr got=%h exp=%h", first_instr, mem_fn(RST_PC)); end
  endtask

  task automatic test_random();
    bit ready, redir;
    logic [31:0] tgt;
    int npops = 0, nredir = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      ready = ($urandom_range(99) < 70);
      redir = ($urandom_range(99) < 6);
      tgt   = ($urandom_range(99) < 15) ? (32'hFFFFFFF0 + 32'($urandom_range(15))) : $urandom;
      drive_cycle(ready, redir, tgt, 75, 0, 3, 10);
      if (redir) nredir++;
      if (ev_pop) begin
        npops++;
        checks++; if (ev_pop_pc !== ev_exp_pop_pc) begin errors++; $display("FAIL rnd_pop_pc cyc=%0d got=%h exp=%h", c, ev_pop_pc, ev_exp_pop_pc); end
        checks++; if (ev_pop_instr !== mem_fn(ev_exp_pop_pc)) begin errors++; $display("FAIL rnd_pop_instr cyc=%0d got=%h exp=%h", c, ev_pop_instr, mem_fn(ev_exp_pop_pc)); end
      end
      checks++; if (s_valid !== (m_occ != 0)) begin errors++; $display("FAIL rnd_if_valid cyc=%0d got=%b exp=%b", c, s_valid, (m_occ != 0)); end
      checks++; if (s_req !== (!m_busy && m_occ < 2)) begin errors++; $display("FAIL rnd_imem_req cyc=%0d got=%b exp=%b", c, s_req, (!m_busy && m_occ < 2)); end
      if (s_req) begin
        checks++; if (s_addr !== m_req_pc) begin errors++; $display("FAIL rnd_imem_addr cyc=%0d got=%h exp=%h", c, s_addr, m_req_pc); end
      end
      if (s_valid) begin
        checks++; if (s_pc !== m_pop_pc) begin errors++; $display("FAIL rnd_head_pc cyc=%0d got=%h exp=%h", c, s_pc, m_pop_pc); end
      end
    end
    $display("random: %0d instructions delivered, %0d redirects", npops, nredir);
  endtask

  initial begin
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.if_ready = 1'b0;
    model_reset();
    test_reset();
    test_sequence();
    test_stall();
    test_redirect_wait();
    test_redirect_full_pop();
    test_wrap();
    test_reset_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
